// File: rtl/serv_rf_ram_seq_if.sv
// serv_rf_ram_seq_if: serial RF side and wide RAM side of the RF sequencer
interface serv_rf_ram_seq_if #(
  parameter int W = 2,
  parameter int WITH_CSR = 1
);
  localparam int RW = 5 + WITH_CSR;
  localparam int AW = RW + 5 - $clog2(W);
  logic rreq;
  logic [RW-1:0] rreg0, rreg1;
  logic ready, rdata0, rdata1;
  logic [RW-1:0] wreg0, wreg1;
  logic wen0, wen1, wdata0, wdata1;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [W-1:0] ram_wdata, ram_rdata;
  logic ram_wen, ram_ren;
  modport slave (
    input rreq, rreg0, rreg1, wreg0, wreg1, wen0, wen1, wdata0, wdata1, ram_rdata,
    output ready, rdata0, rdata1, ram_waddr, ram_wdata, ram_wen, ram_raddr, ram_ren
  );
  modport master (
    output rreq, rreg0, rreg1, wreg0, wreg1, wen0, wen1, wdata0, wdata1, ram_rdata,
    input ready, rdata0, rdata1, ram_waddr, ram_wdata, ram_wen, ram_raddr, ram_ren
  );
endinterface

// File: rtl/serv_rf_ram_seq.sv
// serv_rf_ram_seq: bit-serial two-port RF front end for a W-bit wide 1R1W SRAM
module serv_rf_ram_seq #(
  parameter int W = 2,
  parameter int WITH_CSR = 1
) (
  input logic i_clk,
  input logic i_rst,
  serv_rf_ram_seq_if.slave rf
);
  localparam int LW = $clog2(W);
  localparam int RW = 5 + WITH_CSR;
  localparam int AW = RW + 5 - LW;
  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;
  localparam logic [5:0] TM = 6'(W - 1);
  localparam logic [4:0] WM = 5'(W - 1);
  logic state, busy, ren, load, win, ren_q, sel_q;
  logic [5:0] rcnt;
  logic [RW-1:0] rreg0, rreg1;
  logic [W-1:0] hold0, sh0, sh1;
  assign busy = state == BUSY;
  assign ren = busy && !rcnt[5] && (rcnt & TM) < 6'd2;
  assign load = busy && rcnt >= 6'd2 && rcnt < 6'd34 && ((rcnt - 6'd2) & TM) == 6'd0;
  assign win = busy && rcnt >= 6'd3;
  assign rf.ram_ren = ren;
  assign rf.ram_raddr = ren ? {(rcnt[0] ? rreg1 : rreg0), rcnt[4:LW]} : '0;
  assign rf.ready = busy && rcnt == 6'd2;
  assign rf.rdata0 = win && sh0[0] && |rreg0;
  assign rf.rdata1 = win && sh1[0] && |rreg1;
  // port 1 data lands exactly on the chunk boundary, so it bypasses the holding register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      rcnt <= '0;
      rreg0 <= '0;
      rreg1 <= '0;
      ren_q <= 1'b0;
      sel_q <= 1'b0;
      hold0 <= '0;
      sh0 <= '0;
      sh1 <= '0;
    end else begin
      ren_q <= ren;
      sel_q <= rcnt[0];
      rcnt <= (busy && rcnt != 6'd34) ? rcnt + 6'd1 : '0;
      if (!busy && rf.rreq) begin
        state <= BUSY;
        rreg0 <= rf.rreg0;
        rreg1 <= rf.rreg1;
      end else if (busy && rcnt == 6'd34) state <= IDLE;
      if (ren_q && !sel_q) hold0 <= rf.ram_rdata;
      sh0 <= load ? hold0 : sh0 >> 1;
      sh1 <= load ? rf.ram_rdata : sh1 >> 1;
    end
  end
  logic [4:0] wcnt;
  logic [W-2:0] acc0, acc1;
  logic [W-1:0] nxt0, nxt1, st_data, wdata_r;
  logic [AW-1:0] st_addr, waddr_r;
  logic en, done0, done1, pend1, wen_r;
  assign en = rf.wen0 | rf.wen1;
  assign nxt0 = {rf.wdata0, acc0};
  assign nxt1 = {rf.wdata1, acc1};
  assign done0 = en && (wcnt & WM) == WM && rf.wen0;
  assign done1 = en && (wcnt & WM) == WM && rf.wen1;
  assign rf.ram_wen = wen_r;
  assign rf.ram_waddr = waddr_r;
  assign rf.ram_wdata = wdata_r;
  // port 1 chunks wait one cycle in the stage so they follow port 0 into the single write slot
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wcnt <= '0;
      acc0 <= '0;
      acc1 <= '0;
      pend1 <= 1'b0;
      st_addr <= '0;
      st_data <= '0;
      wen_r <= 1'b0;
      waddr_r <= '0;
      wdata_r <= '0;
    end else begin
      wcnt <= wcnt + 5'(en);
      if (rf.wen0) acc0 <= nxt0[W-1:1];
      if (rf.wen1) acc1 <= nxt1[W-1:1];
      pend1 <= done1;
      if (done1) begin
        st_addr <= {rf.wreg1, wcnt[4:LW]};
        st_data <= nxt1;
      end
      wen_r <= done0 | pend1;
      waddr_r <= done0 ? {rf.wreg0, wcnt[4:LW]} : pend1 ? st_addr : '0;
      wdata_r <= done0 ? nxt0 : pend1 ? st_data : '0;
    end
  end
endmodule

// File: tb/tb_serv_rf_ram_seq.sv
// tb_serv_rf_ram_seq: scoreboard bench running W=2 and W=8 sequencers side by side
module tb_serv_rf_ram_seq;
  typedef struct {logic [31:0] addr; logic [31:0] data; int cyc;} wr_t;
  typedef struct {logic [31:0] d0; logic [31:0] d1;} rd_t;
  logic clk = 1'b0, rst = 1'b1;
  logic rreq = 1'b0, wen0 = 1'b0, wen1 = 1'b0, wdata0 = 1'b0, wdata1 = 1'b0;
  logic [5:0] rreg0 = '0, rreg1 = '0, wreg0 = '0, wreg1 = '0;
  int cyc = 0, checks = 0, failures = 0, rd_t0 = 0, rr = 0;
  int cnt [2] = '{0, 0};
  int stray [2] = '{0, 0};
  logic [31:0] g0 [2], g1 [2];
  logic [63:0] mask [2] = '{64'd0, 64'd0};
  logic [31:0] mdl [64];
  logic [31:0] rv0, rv1;
  rd_t ex [2];
  wr_t wq2[$], wq8[$], we2, we8;
  rd_t rq2[$], rq8[$];
  logic [1:0] mem2 [1024];
  logic [7:0] mem8 [256];
  logic [1:0] rdy, o0, o1, ren;
  serv_rf_ram_seq_if #(.W(2), .WITH_CSR(1)) a();
  serv_rf_ram_seq_if #(.W(8), .WITH_CSR(1)) b();
  serv_rf_ram_seq #(.W(2), .WITH_CSR(1)) dut_a (.i_clk(clk), .i_rst(rst), .rf(a));
  serv_rf_ram_seq #(.W(8), .WITH_CSR(1)) dut_b (.i_clk(clk), .i_rst(rst), .rf(b));
  assign {a.rreq, a.rreg0, a.rreg1, a.wreg0, a.wreg1, a.wen0, a.wen1, a.wdata0, a.wdata1} =
    {rreq, rreg0, rreg1, wreg0, wreg1, wen0, wen1, wdata0, wdata1};
  assign {b.rreq, b.rreg0, b.rreg1, b.wreg0, b.wreg1, b.wen0, b.wen1, b.wdata0, b.wdata1} =
    {rreq, rreg0, rreg1, wreg0, wreg1, wen0, wen1, wdata0, wdata1};
  assign rdy = {b.ready, a.ready};
  assign o0 = {b.rdata0, a.rdata0};
  assign o1 = {b.rdata1, a.rdata1};
  assign ren = {b.ram_ren, a.ram_ren};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (a.ram_wen) mem2[a.ram_waddr] <= a.ram_wdata;
    if (b.ram_wen) mem8[b.ram_waddr] <= b.ram_wdata;
    a.ram_rdata <= a.ram_ren ? mem2[a.ram_raddr] : 2'b0;
    b.ram_rdata <= b.ram_ren ? mem8[b.ram_raddr] : 8'b0;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_of(input int r);
    return r == 0 ? 32'd0 : mdl[r];
  endfunction
  always @(negedge clk) if (!rst && a.ram_wen) begin
    if (wq2.size() == 0) check("wr2_extra", 64'(a.ram_waddr), 64'hFFFF);
    else begin
      we2 = wq2.pop_front();
      check("wr2_addr", 64'(a.ram_waddr), 64'(we2.addr));
      check("wr2_data", 64'(a.ram_wdata), 64'(we2.data));
      check("wr2_cyc", 64'(cyc), 64'(we2.cyc));
    end
  end
  always @(negedge clk) if (!rst && b.ram_wen) begin
    if (wq8.size() == 0) check("wr8_extra", 64'(b.ram_waddr), 64'hFFFF);
    else begin
      we8 = wq8.pop_front();
      check("wr8_addr", 64'(b.ram_waddr), 64'(we8.addr));
      check("wr8_data", 64'(b.ram_wdata), 64'(we8.data));
      check("wr8_cyc", 64'(cyc), 64'(we8.cyc));
    end
  end
  always @(negedge clk) for (int i = 0; i < 2; i++) begin
    if (rreq) mask[i] = 64'd0;
    if (ren[i] && cyc >= rd_t0 && cyc - rd_t0 < 64) mask[i][cyc - rd_t0] = 1'b1;
    if (rst) cnt[i] = 0;
    else if (cnt[i] > 0) begin
      g0[i][32 - cnt[i]] = o0[i];
      g1[i][32 - cnt[i]] = o1[i];
      if (rdy[i]) stray[i]++;
      cnt[i]--;
      if (cnt[i] == 0) begin
        check(i == 0 ? "rd2_p0" : "rd8_p0", 64'(g0[i]), 64'(ex[i].d0));
        check(i == 0 ? "rd2_p1" : "rd8_p1", 64'(g1[i]), 64'(ex[i].d1));
      end
    end else begin
      if (o0[i] | o1[i]) stray[i]++;
      if (rdy[i]) begin
        if ((i == 0 ? rq2.size() : rq8.size()) == 0)
          check(i == 0 ? "rdy2_extra" : "rdy8_extra", 64'(cyc - rd_t0), 64'hFFFF);
        else begin
          if (i == 0) ex[i] = rq2.pop_front();
          else ex[i] = rq8.pop_front();
          check(i == 0 ? "rdy2_t" : "rdy8_t", 64'(cyc - rd_t0), 64'd2);
          cnt[i] = 32;
        end
      end
    end
  end
  task automatic wr(input int r0, input logic [31:0] v0, input logic e0,
                    input int r1, input logic [31:0] v1, input logic e1);
    int st;
    @(posedge clk); #1;
    st = cyc;
    wreg0 = 6'(r0);
    wreg1 = 6'(r1);
    for (int k = 0; k < 32; k++) begin
      wen0 = e0; wen1 = e1; wdata0 = v0[k]; wdata1 = v1[k];
      if (k % 2 == 1) begin
        if (e0) wq2.push_back('{32'(r0 * 16 + k / 2), 32'(v0[k-1 +: 2]), st + k + 1});
        if (e1) wq2.push_back('{32'(r1 * 16 + k / 2), 32'(v1[k-1 +: 2]), st + k + 2});
      end
      if (k % 8 == 7) begin
        if (e0) wq8.push_back('{32'(r0 * 4 + k / 8), 32'(v0[k-7 +: 8]), st + k + 1});
        if (e1) wq8.push_back('{32'(r1 * 4 + k / 8), 32'(v1[k-7 +: 8]), st + k + 2});
      end
      @(posedge clk); #1;
    end
    wen0 = 1'b0; wen1 = 1'b0;
    if (e0) mdl[r0] = v0;
    if (e1) mdl[r1] = v1;
    repeat (3) @(posedge clk);
  endtask
  task automatic push_rd(input int r0, input int r1);
    rq2.push_back('{exp_of(r0), exp_of(r1)});
    rq8.push_back('{exp_of(r0), exp_of(r1)});
  endtask
  task automatic rd(input int r0, input int r1);
    @(posedge clk); #1;
    rreq = 1'b1; rreg0 = 6'(r0); rreg1 = 6'(r1);
    rd_t0 = cyc + 1;
    push_rd(r0, r1);
    @(posedge clk); #1;
    rreq = 1'b0;
    repeat (40) @(posedge clk); #1;
    check("ren_mask2", mask[0], 64'hFFFF_FFFF);
    check("ren_mask8", mask[1], 64'h0303_0303);
    check("rd2_done", 64'(cnt[0]), 64'd0);
    check("rd8_done", 64'(cnt[1]), 64'd0);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mdl[i] = 32'd0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_a", 64'({a.ready, a.rdata0, a.rdata1, a.ram_ren, a.ram_wen, a.ram_waddr, a.ram_wdata, a.ram_raddr}), 64'd0);
    check("rst_b", 64'({b.ready, b.rdata0, b.rdata1, b.ram_ren, b.ram_wen, b.ram_waddr, b.ram_wdata, b.ram_raddr}), 64'd0);
    repeat (5) @(posedge clk); #1;
    check("ren_idle2", mask[0], 64'd0);
    check("ren_idle8", mask[1], 64'd0);
    wr(5, 32'hA5A5_1234, 1'b1, 0, 32'd0, 1'b0);
    rd(5, 0);
    wr(3, 32'hFFFF_FFFF, 1'b1, 34, 32'd0, 1'b1);
    rd(3, 34);
    wr(0, 32'hDEAD_BEEF, 1'b1, 0, 32'd0, 1'b0);
    rd(0, 5);
    for (int k = 0; k < 3; k++) begin
      rr = int'($urandom_range(1, 31));
      rv0 = $urandom;
      rv1 = $urandom;
      wr(rr, rv0, 1'b1, rr + 32, rv1, 1'b1);
      rd(rr + 32, rr);
    end
    @(posedge clk); #1;
    rreq = 1'b1; rreg0 = 6'd5; rreg1 = 6'd3;
    rd_t0 = cyc + 1;
    push_rd(5, 3);
    @(posedge clk); #1;
    rreq = 1'b0;
    repeat (5) @(posedge clk); #1;
    rreq = 1'b1; rreg0 = 6'd3; rreg1 = 6'd5;
    @(posedge clk); #1;
    rreq = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_a", 64'({a.ready, a.rdata0, a.rdata1, a.ram_ren, a.ram_wen, a.ram_raddr}), 64'd0);
    check("abort_b", 64'({b.ready, b.rdata0, b.rdata1, b.ram_ren, b.ram_wen, b.ram_raddr}), 64'd0);
    rd(3, 5);
    repeat (5) @(posedge clk);
    check("wq2_left", 64'(wq2.size()), 64'd0);
    check("wq8_left", 64'(wq8.size()), 64'd0);
    check("rq2_left", 64'(rq2.size()), 64'd0);
    check("rq8_left", 64'(rq8.size()), 64'd0);
    check("stray2", 64'(stray[0]), 64'd0);
    check("stray8", 64'(stray[1]), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
